// File: rtl/udp_port_gate.sv
// udp_port_gate: parses Ethernet/IPv4/UDP headers on the receive octet
// stream and hands only the UDP payload of frames addressed to udp_port
// to the client. The frame-good verdict is forwarded as a crc pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | between frames, waiting for rx_strobe to rise
// HEADER   | checking header octets 0..39
// PAYLOAD  | header matched, streaming UDP payload octets
// TRAIL    | payload done, ignoring padding until rx_strobe falls
// WAIT_CRC | frame over, waiting for the ok/bad verdict
// DROP     | frame rejected, waiting for rx_strobe to fall
module udp_port_gate #(
   parameter int          jumbo_dw = 14,
   parameter logic [15:0] udp_port = 16'd1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_strobe,
   input  logic [7:0]  rx_data,
   input  logic        rx_crc_ok,
   input  logic        rx_crc_bad,
   output logic        ready,
   output logic        strobe,
   output logic [7:0]  data_out,
   output logic        crc,
   output logic [15:0] accept_cnt,
   output logic [15:0] drop_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_PAYLOAD, S_TRAIL, S_WAIT_CRC, S_DROP
   } state_t;

   localparam logic [jumbo_dw-1:0] CNT_MAX  = '1;
   localparam logic [jumbo_dw-1:0] IDX_ET0  = jumbo_dw'(12);
   localparam logic [jumbo_dw-1:0] IDX_ET1  = jumbo_dw'(13);
   localparam logic [jumbo_dw-1:0] IDX_VIHL = jumbo_dw'(14);
   localparam logic [jumbo_dw-1:0] IDX_PROT = jumbo_dw'(23);
   localparam logic [jumbo_dw-1:0] IDX_DP0  = jumbo_dw'(36);
   localparam logic [jumbo_dw-1:0] IDX_DP1  = jumbo_dw'(37);
   localparam logic [jumbo_dw-1:0] IDX_LEN0 = jumbo_dw'(38);
   localparam logic [jumbo_dw-1:0] IDX_LEN1 = jumbo_dw'(39);
   localparam logic [jumbo_dw-1:0] IDX_PAY  = jumbo_dw'(42);

   state_t              state_q, state_d;
   logic [jumbo_dw-1:0] cnt_q, cnt_d;
   logic                ovl_q, ovl_d;
   logic                stb_prev_q;
   logic [7:0]          len_hi_q, len_hi_d;
   logic [15:0]         rem_q, rem_d;
   logic                ready_q, ready_d;
   logic                strobe_q;
   logic [7:0]          data_q;
   logic                crc_q, crc_d;
   logic [15:0]         acc_q, drop_q;

   logic        rise;
   logic        cnt_sat;
   logic        hdr_ok;
   logic        emit;
   logic        acc_inc;
   logic        drop_inc;
   logic [15:0] len_full;

   // Header checks, frame position tracking and state transitions.
   always_comb begin
      rise     = rx_strobe & ~stb_prev_q;
      cnt_sat  = (cnt_q == CNT_MAX);
      len_full = {len_hi_q, rx_data};

      hdr_ok = 1'b1;
      if (cnt_q == IDX_ET0)  hdr_ok = (rx_data == 8'h08);
      if (cnt_q == IDX_ET1)  hdr_ok = (rx_data == 8'h00);
      if (cnt_q == IDX_VIHL) hdr_ok = (rx_data == 8'h45);
      if (cnt_q == IDX_PROT) hdr_ok = (rx_data == 8'h11);
      if (cnt_q == IDX_DP0)  hdr_ok = (rx_data == udp_port[15:8]);
      if (cnt_q == IDX_DP1)  hdr_ok = (rx_data == udp_port[7:0]);
      if (cnt_q == IDX_LEN1) hdr_ok = (len_full >= 16'd8);

      // The index restarts during every inter-frame gap; it saturates
      // rather than wrapping so an overlong frame cannot alias a header.
      cnt_d = rx_strobe ? (cnt_sat ? cnt_q : cnt_q + 1'b1) : '0;
      ovl_d = rise ? 1'b0 : (ovl_q | (rx_strobe & cnt_sat));

      state_d  = state_q;
      ready_d  = ready_q;
      len_hi_d = (cnt_q == IDX_LEN0) ? rx_data : len_hi_q;
      rem_d    = rem_q;
      emit     = 1'b0;
      crc_d    = 1'b0;
      acc_inc  = 1'b0;
      drop_inc = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rise) state_d = S_HEADER;
         end
         S_HEADER: begin
            if (!rx_strobe) begin
               state_d  = S_IDLE;
               drop_inc = 1'b1;
            end else if (!hdr_ok) begin
               state_d = S_DROP;
            end else if (cnt_q == IDX_LEN1) begin
               ready_d = 1'b1;
               rem_d   = len_full - 16'd8;
               state_d = (len_full == 16'd8) ? S_TRAIL : S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (!rx_strobe) begin
               state_d  = S_IDLE;
               ready_d  = 1'b0;
               drop_inc = 1'b1;
            end else if (cnt_q >= IDX_PAY) begin
               emit  = 1'b1;
               rem_d = rem_q - 16'd1;
               if (rem_q == 16'd1) state_d = S_TRAIL;
            end
         end
         S_TRAIL: begin
            if (!rx_strobe) state_d = S_WAIT_CRC;
         end
         S_WAIT_CRC: begin
            // A new frame may start in the same cycle as the verdict.
            if (rx_crc_bad || (rx_crc_ok && ovl_q)) begin
               ready_d  = 1'b0;
               drop_inc = 1'b1;
               state_d  = rise ? S_HEADER : S_IDLE;
            end else if (rx_crc_ok) begin
               ready_d = 1'b0;
               crc_d   = 1'b1;
               acc_inc = 1'b1;
               state_d = rise ? S_HEADER : S_IDLE;
            end else if (rise) begin
               ready_d  = 1'b0;
               drop_inc = 1'b1;
               state_d  = S_HEADER;
            end
         end
         S_DROP: begin
            if (!rx_strobe) begin
               state_d  = S_IDLE;
               drop_inc = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; rx_strobe history resets high so a frame already in
   // flight at reset release is not mistaken for a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ovl_q      <= 1'b0;
         stb_prev_q <= 1'b1;
         len_hi_q   <= 8'h00;
         rem_q      <= 16'h0000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovl_q      <= ovl_d;
         stb_prev_q <= rx_strobe;
         len_hi_q   <= len_hi_d;
         rem_q      <= rem_d;
      end
   end

   // Client-facing outputs and saturating frame counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q  <= 1'b0;
         strobe_q <= 1'b0;
         data_q   <= 8'h00;
         crc_q    <= 1'b0;
         acc_q    <= 16'h0000;
         drop_q   <= 16'h0000;
      end else begin
         ready_q  <= ready_d;
         strobe_q <= emit;
         data_q   <= emit ? rx_data : data_q;
         crc_q    <= crc_d;
         if (acc_inc && (acc_q != 16'hFFFF))   acc_q  <= acc_q + 16'd1;
         if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      end
   end

   assign ready      = ready_q;
   assign strobe     = strobe_q;
   assign data_out   = data_q;
   assign crc        = crc_q;
   assign accept_cnt = acc_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_udp_port_gate.sv
// Bench for udp_port_gate: directed frames, payload/crc expectations
// queued by the driver and checked by independent monitors.
module tb_udp_port_gate;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb_a = 1'b0, ok_a = 1'b0, bad_a = 1'b0;
   logic [7:0]  dat_a = 8'h00;
   logic        stb_b = 1'b0, ok_b = 1'b0, bad_b = 1'b0;
   logic [7:0]  dat_b = 8'h00;
   logic        ready_a, strobe_a, crc_a, ready_b, strobe_b, crc_b;
   logic [7:0]  data_a, data_b;
   logic [15:0] acc_a, drop_a, acc_b, drop_b;

   udp_port_gate dut_a (
      .clk(clk), .rst_n(rst_n), .rx_strobe(stb_a), .rx_data(dat_a),
      .rx_crc_ok(ok_a), .rx_crc_bad(bad_a), .ready(ready_a),
      .strobe(strobe_a), .data_out(data_a), .crc(crc_a),
      .accept_cnt(acc_a), .drop_cnt(drop_a));

   udp_port_gate #(.jumbo_dw(11)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx_strobe(stb_b), .rx_data(dat_b),
      .rx_crc_ok(ok_b), .rx_crc_bad(bad_b), .ready(ready_b),
      .strobe(strobe_b), .data_out(data_b), .crc(crc_b),
      .accept_cnt(acc_b), .drop_cnt(drop_b));

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int     val;   // 0..255 payload octet, 256 crc pulse
      longint cyc;
   } exp_t;

   exp_t       qa[$];
   exp_t       qb[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] fb [0:2199];

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic mon_event(input int which, input int val);
      exp_t e;
      n_vec++;
      if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
         n_err++;
         $display("FAIL unexpected_out dut%0d: got %0d at cycle %0d expected nothing", which, val, cyc);
      end else begin
         e = (which == 0) ? qa.pop_front() : qb.pop_front();
         if (e.val != val || e.cyc != cyc) begin
            n_err++;
            $display("FAIL out_event dut%0d: got %0d at cycle %0d expected %0d at cycle %0d",
                     which, val, cyc, e.val, e.cyc);
         end
      end
   endtask

   // Monitors: every strobe or crc cycle must match the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (strobe_a) mon_event(0, int'(data_a));
         if (crc_a)    mon_event(0, 256);
         if (strobe_b) mon_event(1, int'(data_b));
         if (crc_b)    mon_event(1, 256);
      end
   end

   task automatic push(input int which, input int val);
      exp_t e;
      e.val = val;
      e.cyc = cyc + 1;
      if (which == 0) qa.push_back(e);
      else            qb.push_back(e);
   endtask

   task automatic oc(input int which, input logic s, input logic [7:0] d,
                     input logic ok, input logic bad);
      @(posedge clk);
      #1;
      if (which == 0) begin stb_a = s; dat_a = d; ok_a = ok; bad_a = bad; end
      else            begin stb_b = s; dat_b = d; ok_b = ok; bad_b = bad; end
   endtask

   function automatic logic rdy(input int which);
      return (which == 0) ? ready_a : ready_b;
   endfunction

   task automatic build_frame(input int port, input int len, input int n);
      for (int i = 0; i < n; i++) fb[i] = 8'hEE;
      for (int i = 0; i < 12; i++) fb[i] = 8'(8'h10 + i);
      fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[15] = 8'h00;
      fb[16] = 8'((len + 20) >> 8); fb[17] = 8'(len + 20);
      for (int i = 18; i < 23; i++) fb[i] = 8'h00;
      fb[22] = 8'h40; fb[23] = 8'h11;
      for (int i = 24; i < 34; i++) fb[i] = 8'(i);
      fb[34] = 8'h12; fb[35] = 8'h34;
      fb[36] = 8'(port >> 8); fb[37] = 8'(port);
      fb[38] = 8'(len >> 8);  fb[39] = 8'(len);
      fb[40] = 8'h00; fb[41] = 8'h00;
      for (int j = 0; j < len - 8 && 42 + j < n; j++)
         fb[42 + j] = (j == 0) ? 8'hA5 : (j == 1) ? 8'h3C : 8'(j * 13 + 5);
   endtask

   task automatic send_frame(input int which, input int from, input int to,
                             input int len, input bit exp_pay, input bit chk_rdy,
                             input bit rdy_exp, input bit ok_first, input bit crc_first);
      for (int i = from; i < to; i++) begin
         oc(which, 1'b1, fb[i], (i == from) && ok_first, 1'b0);
         if (i == from && crc_first) push(which, 256);
         if (exp_pay && i >= 42 && i <= 42 + len - 9) push(which, int'(fb[i]));
         if (chk_rdy && (i == 39 || i == 40)) begin
            @(negedge clk);
            if (i == 39) check("ready_before_40", rdy(which), 0);
            else         check("ready_at_40", rdy(which), rdy_exp);
         end
      end
   endtask

   task automatic end_frame(input int which);
      oc(which, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic verdict(input int which, input logic ok, input logic bad, input bit exp_crc);
      oc(which, 1'b0, 8'h00, ok, bad);
      if (exp_crc) push(which, 256);
      oc(which, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      check("ready_after_verdict", rdy(which), 0);
   endtask

   task automatic chk_cnt(input int which, input string tag, input int acc, input int drp);
      repeat (2) @(negedge clk);
      check({tag, "_accept"}, (which == 0) ? acc_a : acc_b, acc);
      check({tag, "_drop"},   (which == 0) ? drop_a : drop_b, drp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      stb_a = 1'b0; ok_a = 1'b0; bad_a = 1'b0; dat_a = 8'h00;
      stb_b = 1'b0; ok_b = 1'b0; bad_b = 1'b0; dat_b = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_ready", ready_a, 0);
      check("rst_strobe", strobe_a, 0);
      check("rst_data", data_a, 0);
      check("rst_crc", crc_a, 0);
      check("rst_accept", acc_a, 0);
      check("rst_drop", drop_a, 0);
      do_reset();

      // 1: matched frame, L=10, payload A5 3C, good
      build_frame(1000, 10, 44);
      send_frame(0, 0, 44, 10, 1, 1, 1, 0, 0);
      end_frame(0);
      verdict(0, 1'b1, 1'b0, 1);
      chk_cnt(0, "t1", 1, 0);

      // 2: wrong port
      do_reset();
      build_frame(1001, 10, 60);
      send_frame(0, 0, 60, 10, 0, 1, 0, 0, 0);
      end_frame(0);
      verdict(0, 1'b1, 1'b0, 0);
      chk_cnt(0, "t2", 0, 1);

      // 3: matched frame, bad FCS
      do_reset();
      build_frame(1000, 10, 60);
      send_frame(0, 0, 60, 10, 1, 1, 1, 0, 0);
      end_frame(0);
      verdict(0, 1'b0, 1'b1, 0);
      chk_cnt(0, "t3", 0, 1);

      // 4: padded frame, then back-to-back frame with verdict on its first octet
      do_reset();
      build_frame(1000, 10, 60);
      send_frame(0, 0, 60, 10, 1, 1, 1, 0, 0);
      end_frame(0);
      send_frame(0, 0, 60, 10, 1, 1, 1, 1, 1);
      end_frame(0);
      verdict(0, 1'b1, 1'b0, 1);
      chk_cnt(0, "t4", 2, 0);

      // 5a: truncated at index 43 with L=20
      do_reset();
      build_frame(1000, 20, 60);
      send_frame(0, 0, 44, 20, 1, 1, 1, 0, 0);
      end_frame(0);
      verdict(0, 1'b1, 1'b0, 0);
      chk_cnt(0, "t5a", 0, 1);

      // 5b: reset at index 31, remainder of frame ignored
      build_frame(1000, 10, 60);
      send_frame(0, 0, 31, 10, 0, 0, 0, 0, 0);
      oc(0, 1'b1, fb[31], 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("t5b_rst_drop", drop_a, 0);
      check("t5b_rst_ready", ready_a, 0);
      check("t5b_rst_strobe", strobe_a, 0);
      oc(0, 1'b1, fb[32], 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(0, 33, 60, 10, 0, 0, 0, 0, 0);
      end_frame(0);
      verdict(0, 1'b1, 1'b0, 0);
      chk_cnt(0, "t5b_ignored", 0, 0);
      send_frame(0, 0, 60, 10, 1, 1, 1, 0, 0);
      end_frame(0);
      verdict(0, 1'b1, 1'b0, 1);
      chk_cnt(0, "t5b_recover", 1, 0);

      // L=8: empty payload, crc still pulses
      do_reset();
      build_frame(1000, 8, 60);
      send_frame(0, 0, 60, 8, 1, 1, 1, 0, 0);
      end_frame(0);
      verdict(0, 1'b1, 1'b0, 1);
      chk_cnt(0, "l8", 1, 0);

      // L=7: illegal UDP length
      do_reset();
      build_frame(1000, 7, 60);
      send_frame(0, 0, 60, 7, 0, 1, 0, 0, 0);
      end_frame(0);
      verdict(0, 1'b1, 1'b0, 0);
      chk_cnt(0, "l7", 0, 1);

      // 6: 11-bit index, 2100-octet frame saturates and is dropped
      do_reset();
      build_frame(1000, 10, 2100);
      send_frame(1, 0, 2100, 10, 1, 1, 1, 0, 0);
      @(negedge clk);
      check("t6_cnt_sat", dut_b.cnt_q, 2047);
      end_frame(1);
      verdict(1, 1'b1, 1'b0, 0);
      chk_cnt(1, "t6", 0, 1);

      repeat (4) @(negedge clk);
      check("queue_a_drained", qa.size(), 0);
      check("queue_b_drained", qb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
